maxpool_seq: RTL

MAXPOOL_SEQ -- requirements
Module: maxpool_seq

---
 rtl/maxpool_pkg.sv | 15 +
 rtl/maxpool_dp.sv | 40 ++++
 rtl/maxpool_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the sequential max-pool block: FSM encoding and
// default configuration widths.
package maxpool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int N_DEF  = 32;
  localparam int WW_DEF = 4;
  localparam int NW_DEF = 8;

endpackage

// File: rtl/maxpool_dp.sv
// Max-pool datapath: a single result register that either loads the input
// or keeps the signed running maximum of itself and the input.
module maxpool_dp #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                max_clr,
  input  logic                max_en,
  input  logic                max_pool,
  input  logic signed [N-1:0] I,
  output logic signed [N-1:0] O
);

  logic signed [N-1:0] acc_q;
  logic signed [N-1:0] acc_d;

  function automatic logic signed [N-1:0] smax(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (max_en) begin
      acc_d = max_pool ? smax(acc_q, I) : I;
    end
  end

  // Clear has priority so a reset always empties the result register.
  always_ff @(posedge clk) begin
    if (max_clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign O = acc_q;

endmodule

// File: rtl/maxpool_seq.sv
// Sequential max-pool controller: accepts cfg_win elements per window,
// emits the signed maximum of each window, cfg_nwin windows per frame.
module maxpool_seq
  import maxpool_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int WW = WW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WW-1:0]       cfg_win,
  input  logic [NW-1:0]       cfg_nwin,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                busy,
  output logic                done
);

  state_t        state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [WW-1:0] ecnt_q, ecnt_d;
  logic [NW-1:0] nwin_q, nwin_d;
  logic [NW-1:0] wcnt_q, wcnt_d;
  logic          clr_q;

  logic          en;
  logic          pool;
  logic          last_elem;
  logic          last_win;
  logic          out_hs;

  function automatic logic [WW-1:0] fix_win(input logic [WW-1:0] v);
    return (v == '0) ? WW'(1) : v;
  endfunction

  function automatic logic [NW-1:0] fix_nwin(input logic [NW-1:0] v);
    return (v == '0) ? NW'(1) : v;
  endfunction

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign en        = in_valid & in_ready;
  assign pool      = (ecnt_q != '0);
  assign last_elem = (ecnt_q == win_q - WW'(1));
  assign last_win  = (wcnt_q == nwin_q - NW'(1));
  assign out_hs    = out_valid & out_ready;
  assign done      = out_hs & last_win;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    nwin_d  = nwin_q;
    ecnt_d  = ecnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_d   = fix_win(cfg_win);
          nwin_d  = fix_nwin(cfg_nwin);
          ecnt_d  = '0;
          wcnt_d  = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (en) begin
          if (last_elem) begin
            ecnt_d  = '0;
            state_d = ST_HOLD;
          end else begin
            ecnt_d = ecnt_q + WW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_hs) begin
          if (last_win) begin
            wcnt_d  = '0;
            ecnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            wcnt_d  = wcnt_q + NW'(1);
            state_d = ST_ACCUM;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= WW'(1);
      nwin_q  <= NW'(1);
      ecnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      nwin_q  <= nwin_d;
      ecnt_q  <= ecnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Datapath clear lags reset by one edge; the result register is not reset directly.
  always_ff @(posedge clk) begin
    clr_q <= ~rst_n;
  end

  maxpool_dp #(
    .N(N)
  ) u_dp (
    .clk     (clk),
    .max_clr (clr_q),
    .max_en  (en),
    .max_pool(pool),
    .I       (in_data),
    .O       (out_data)
  );

endmodule
